priority_drain: RTL and testbench

PRIORITY_DRAIN -- requirements
Module: priority_drain

---
 rtl/priority_drain.sv | 104 ++++++++++
 tb/tb_priority_drain.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_drain.sv
// Priority drain: grants the pending request bits one at a time, lowest index first.
// Define PRIORITY_DRAIN_INDEX_EN to add the binary grant index output gnt_idx.
module priority_drain #(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] req_pry,
  output logic             gnt_vld,
  input  logic             gnt_rdy,
  output logic [WIDTH-1:0] gnt_oht,
  output logic             gnt_lst
`ifdef PRIORITY_DRAIN_INDEX_EN
  ,
  output logic [WIDTH_LOG-1:0] gnt_idx
`endif
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pnd_q, pnd_d;
  logic [WIDTH-1:0] iso;

  generate
    if (IMPLEMENTATION == 0) begin : g_add
      assign iso = pnd_q & (~pnd_q + WIDTH'(1));
    end else begin : g_loop
      logic found;
      always_comb begin
        iso   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          if (pnd_q[i] && !found) begin
            iso[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    pnd_d   = pnd_q;
    req_rdy = 1'b1;
    gnt_vld = 1'b0;
    gnt_oht = '0;
    gnt_lst = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_vld && |req_pry) begin
          pnd_d   = req_pry;
          state_d = BUSY;
        end
      end
      BUSY: begin
        gnt_vld = 1'b1;
        gnt_oht = iso;
        gnt_lst = ~|(pnd_q & ~iso);
        req_rdy = gnt_rdy & gnt_lst;
        if (gnt_rdy) begin
          pnd_d = pnd_q & ~iso;
          // last grant consumed: refill back-to-back or fall idle
          if (gnt_lst) begin
            if (req_vld && |req_pry) begin
              pnd_d = req_pry;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PRIORITY_DRAIN_INDEX_EN
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt_oht[i]) gnt_idx = gnt_idx | WIDTH_LOG'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pnd_q   <= '0;
    end else begin
      state_q <= state_d;
      pnd_q   <= pnd_d;
    end
  end

endmodule

// File: tb/tb_priority_drain.sv
// Bench for priority_drain: both implementations against a queue-of-indices model.
// Directed cases pin the model; random traffic follows.
module tb_priority_drain;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_vld;
  logic         gnt_rdy;
  logic [W-1:0] req_pry;

  logic         rdy0, rdy1, vld0, vld1, lst0, lst1;
  logic [W-1:0] oht0, oht1;
`ifdef PRIORITY_DRAIN_INDEX_EN
  logic [2:0]   idx0, idx1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int pq[$];

  always #5 clk = ~clk;

  priority_drain #(.WIDTH(W), .IMPLEMENTATION(0)) u0 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(rdy0),
    .req_pry(req_pry), .gnt_vld(vld0), .gnt_rdy(gnt_rdy),
    .gnt_oht(oht0), .gnt_lst(lst0)
`ifdef PRIORITY_DRAIN_INDEX_EN
    , .gnt_idx(idx0)
`endif
  );

  priority_drain #(.WIDTH(W), .IMPLEMENTATION(1)) u1 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(rdy1),
    .req_pry(req_pry), .gnt_vld(vld1), .gnt_rdy(gnt_rdy),
    .gnt_oht(oht1), .gnt_lst(lst1)
`ifdef PRIORITY_DRAIN_INDEX_EN
    , .gnt_idx(idx1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: pending bits as an ascending list of indices
  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      pq.delete();
    end else begin
      acc = (pq.size() == 0) || (gnt_rdy && pq.size() == 1);
      if (pq.size() != 0 && gnt_rdy) void'(pq.pop_front());
      if (acc && req_vld) begin
        for (int i = 0; i < W; i++) if (req_pry[i]) pq.push_back(i);
      end
    end
  end

  always @(negedge clk) begin
    logic         e_vld, e_lst, e_rdy;
    logic [W-1:0] e_oht;
    e_vld = pq.size() != 0;
    e_oht = e_vld ? W'(1) << pq[0] : '0;
    e_lst = pq.size() == 1;
    e_rdy = !e_vld || (gnt_rdy && e_lst);
    chk("m0.vld", vld0, e_vld);
    chk("m0.oht", oht0, e_oht);
    chk("m0.lst", lst0, e_lst);
    chk("m0.rdy", rdy0, e_rdy);
    chk("m1.vld", vld1, e_vld);
    chk("m1.oht", oht1, e_oht);
    chk("m1.lst", lst1, e_lst);
    chk("m1.rdy", rdy1, e_rdy);
`ifdef PRIORITY_DRAIN_INDEX_EN
    chk("m0.idx", idx0, e_vld ? pq[0] : 0);
    chk("m1.idx", idx1, e_vld ? pq[0] : 0);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic v, input logic [W-1:0] o,
                     input logic l);
    #1;
    chk({nm, ".vld0"}, vld0, v);
    chk({nm, ".oht0"}, oht0, o);
    chk({nm, ".lst0"}, lst0, l);
    chk({nm, ".vld1"}, vld1, v);
    chk({nm, ".oht1"}, oht1, o);
    chk({nm, ".lst1"}, lst1, l);
  endtask

`ifdef PRIORITY_DRAIN_INDEX_EN
  task automatic lidx(input string nm, input int e);
    chk({nm, ".idx0"}, idx0, e);
    chk({nm, ".idx1"}, idx1, e);
  endtask
`endif

  initial begin
    logic [W-1:0] v;
    int           g[4];
    rst     = 1'b1;
    req_vld = 1'b0;
    gnt_rdy = 1'b0;
    req_pry = '0;
    #1;
    lit("reset", 1'b0, 8'h00, 1'b0);
    chk("reset.rdy0", rdy0, 1'b1);
    chk("reset.rdy1", rdy1, 1'b1);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // single vector
    req_vld = 1'b1;
    req_pry = 8'hA6;
    gnt_rdy = 1'b1;
    cyc();
    req_vld = 1'b0;
    g = '{1, 2, 5, 7};
    for (int i = 0; i < 4; i++) begin
      lit("single", 1'b1, W'(1) << g[i], i == 3);
`ifdef PRIORITY_DRAIN_INDEX_EN
      lidx("single", g[i]);
`endif
      cyc();
    end
    lit("single.end", 1'b0, 8'h00, 1'b0);

    // backpressure
    req_vld = 1'b1;
    req_pry = 8'h81;
    gnt_rdy = 1'b0;
    cyc();
    req_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lit("bp.hold", 1'b1, 8'h01, 1'b0);
      cyc();
    end
    gnt_rdy = 1'b1;
    lit("bp.go", 1'b1, 8'h01, 1'b0);
    cyc();
    lit("bp.last", 1'b1, 8'h80, 1'b1);
    cyc();

    // back-to-back
    req_vld = 1'b1;
    req_pry = 8'h03;
    cyc();
    req_pry = 8'h40;
    lit("b2b.0", 1'b1, 8'h01, 1'b0);
    chk("b2b.rdy_lo", rdy0, 1'b0);
    cyc();
    lit("b2b.1", 1'b1, 8'h02, 1'b1);
    chk("b2b.rdy_hi0", rdy0, 1'b1);
    chk("b2b.rdy_hi1", rdy1, 1'b1);
    cyc();
    req_vld = 1'b0;
    lit("b2b.2", 1'b1, 8'h40, 1'b1);
    cyc();

    // zero vector, full vector, top bit alone
    req_vld = 1'b1;
    req_pry = 8'h00;
    cyc();
    req_vld = 1'b0;
    lit("zero", 1'b0, 8'h00, 1'b0);
    chk("zero.rdy", rdy0, 1'b1);
    req_vld = 1'b1;
    req_pry = 8'hFF;
    cyc();
    req_vld = 1'b0;
    for (int i = 0; i < W; i++) begin
      lit("full", 1'b1, W'(1) << i, i == W - 1);
      cyc();
    end
    lit("full.end", 1'b0, 8'h00, 1'b0);
    req_vld = 1'b1;
    req_pry = 8'h80;
    cyc();
    req_vld = 1'b0;
    lit("top", 1'b1, 8'h80, 1'b1);
    cyc();
    lit("top.end", 1'b0, 8'h00, 1'b0);

    // reset mid-drain, with handshakes offered during reset
    req_vld = 1'b1;
    req_pry = 8'hF0;
    cyc();
    req_vld = 1'b0;
    lit("rd.first", 1'b1, 8'h10, 1'b0);
    cyc();
    #2;
    rst = 1'b1;
    lit("rd.async", 1'b0, 8'h00, 1'b0);
    chk("rd.rdy", rdy0, 1'b1);
    cyc();
    req_vld = 1'b1;
    req_pry = 8'h55;
    cyc();
    req_vld = 1'b0;
    rst = 1'b0;
    lit("rd.rel", 1'b0, 8'h00, 1'b0);
    chk("rd.rel.rdy", rdy1, 1'b1);
    cyc();
    lit("rd.quiet", 1'b0, 8'h00, 1'b0);
    req_vld = 1'b1;
    req_pry = 8'h08;
    cyc();
    req_vld = 1'b0;
    lit("rd.next", 1'b1, 8'h08, 1'b1);
    cyc();
    lit("rd.done", 1'b0, 8'h00, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      v = W'($urandom);
      if ($urandom_range(0, 7) == 0) v = '0;
      if ($urandom_range(0, 7) == 0) v = W'(1) << $urandom_range(0, W - 1);
      req_pry = v;
      req_vld = $urandom_range(0, 3) != 0;
      gnt_rdy = $urandom_range(0, 3) != 0;
      rst     = $urandom_range(0, 199) == 0;
      cyc();
    end
    rst = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
